// File: rtl/led_pattern_driver.sv
// -----------------------------------------------------------------------------
// led_pattern_driver
//
// Purpose:
//   Drives a single LED with one of four patterns selected by a command
//   handshake: OFF, ON (fixed PWM duty), BLINK (PWM duty gated by a
//   half-period measured in 10 ms ticks) and BREATHE (PWM duty ramping
//   0 -> peak -> 0 one step per tick). The PWM carrier is a free-running
//   8-bit counter, so a duty of N lights the LED for N of every 256 clocks.
//
// Optional feature:
//   BREATHE mode is only built when macro LED_PATTERN_BREATHE_EN is defined.
//   Without it, an accepted mode 3 behaves exactly like mode 0 (OFF) and the
//   handshake is unchanged.
//
// Parameters:
//   CLK_CYCLES  - clk cycles per second
//   TICK_CYCLES - clk cycles per 10 ms pattern tick
//
// Ports:
//   clk        in   1  system clock, all logic on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   cmd_valid  in   1  command offered
//   cmd_ready  out  1  command can be accepted (low for the one APPLY cycle)
//   cmd_mode   in   2  0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//   cmd_duty   in   8  PWM duty (ON/BLINK) or peak duty (BREATHE)
//   cmd_period in   8  BLINK half-period in ticks (0 behaves as 1)
//   led        out  1  registered LED drive, 1 = lit
// -----------------------------------------------------------------------------
module led_pattern_driver #(
    parameter int CLK_CYCLES  = 50_000_000,
    parameter int TICK_CYCLES = CLK_CYCLES / 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_duty,
    input  logic [7:0] cmd_period,
    output logic       led
);

    // Prescaler width: wide enough to hold TICK_CYCLES-1.
    localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    // S_APPLY is the single cycle after acceptance; the pattern state is
    // chosen from the latched mode when it ends.
    typedef enum logic [2:0] {
        S_OFF          = 3'd0,
        S_ON           = 3'd1,
        S_BLINK_ON     = 3'd2,
        S_BLINK_OFF    = 3'd3,
        S_APPLY        = 3'd4
`ifdef LED_PATTERN_BREATHE_EN
        ,
        S_BREATHE_UP   = 3'd5,
        S_BREATHE_DOWN = 3'd6
`endif
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t        r_state;
    logic          r_cmd_ready;
    logic [1:0]    r_mode;
    logic [7:0]    r_duty;
    logic [7:0]    r_period;
    logic [7:0]    r_pwm_cnt;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_tick_cnt;
    logic [7:0]    r_active_duty;
    logic          r_led;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic          w_accept;
    logic          w_tick;
    logic [7:0]    w_period_last;
    logic [7:0]    w_duty_sel;
    logic          w_lit;
    logic          w_pwm_on;
    state_t        w_state_next;
    logic [7:0]    w_tick_cnt_next;
    logic [7:0]    w_active_duty_next;

    assign w_accept  = cmd_valid & r_cmd_ready;
    assign w_tick    = (r_presc == TICK_LAST);

    // A half-period of 0 ticks would never toggle; treat it as 1.
    assign w_period_last = (r_period == 8'd0) ? 8'd0 : (r_period - 8'd1);

    assign w_pwm_on  = (r_pwm_cnt < w_duty_sel);

    assign cmd_ready = r_cmd_ready;
    assign led       = r_led;

    // -------------------------------------------------------------------------
    // FSM state register and pattern datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_OFF;
            r_tick_cnt    <= 8'd0;
            r_active_duty <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_tick_cnt    <= w_tick_cnt_next;
            r_active_duty <= w_active_duty_next;
        end
    end

    // -------------------------------------------------------------------------
    // Command handshake and latched fields. Fields only change on an
    // accepted command, so the pattern ignores input wiggles between commands.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b0;
            r_mode      <= 2'd0;
            r_duty      <= 8'd0;
            r_period    <= 8'd0;
        end else begin
            // Ready comes up on the first edge out of reset and drops for
            // exactly the one cycle following each acceptance.
            r_cmd_ready <= ~w_accept;
            if (w_accept) begin
                r_mode   <= cmd_mode;
                r_duty   <= cmd_duty;
                r_period <= cmd_period;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PWM carrier (free-running) and tick prescaler (restarted per command so
    // the first tick of a new pattern is a full TICK_CYCLES after acceptance).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'd0;
            r_presc   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_accept || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // LED output register: one clock behind the PWM counter and state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_lit & w_pwm_on;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_tick_cnt_next    = r_tick_cnt;
        w_active_duty_next = r_active_duty;
        w_duty_sel         = 8'd0;
        w_lit              = 1'b0;

        // Outputs depend only on the current state.
        case (r_state)
            S_ON,
            S_BLINK_ON: begin
                w_lit      = 1'b1;
                w_duty_sel = r_duty;
            end
`ifdef LED_PATTERN_BREATHE_EN
            S_BREATHE_UP,
            S_BREATHE_DOWN: begin
                w_lit      = 1'b1;
                w_duty_sel = r_active_duty;
            end
`endif
            default: begin
                w_lit      = 1'b0;
                w_duty_sel = 8'd0;
            end
        endcase

        if (w_accept) begin
            // A new command abandons whatever pattern is running.
            w_state_next       = S_APPLY;
            w_tick_cnt_next    = 8'd0;
            w_active_duty_next = 8'd0;
        end else begin
            case (r_state)
                S_APPLY: begin
                    w_tick_cnt_next    = 8'd0;
                    w_active_duty_next = 8'd0;
                    case (r_mode)
                        2'd1:    w_state_next = S_ON;
                        2'd2:    w_state_next = S_BLINK_ON;
`ifdef LED_PATTERN_BREATHE_EN
                        2'd3:    w_state_next = S_BREATHE_UP;
`endif
                        default: w_state_next = S_OFF;
                    endcase
                end

                S_BLINK_ON: begin
                    if (w_tick) begin
                        if (r_tick_cnt == w_period_last) begin
                            w_state_next    = S_BLINK_OFF;
                            w_tick_cnt_next = 8'd0;
                        end else begin
                            w_tick_cnt_next = r_tick_cnt + 8'd1;
                        end
                    end
                end

                S_BLINK_OFF: begin
                    if (w_tick) begin
                        if (r_tick_cnt == w_period_last) begin
                            w_state_next    = S_BLINK_ON;
                            w_tick_cnt_next = 8'd0;
                        end else begin
                            w_tick_cnt_next = r_tick_cnt + 8'd1;
                        end
                    end
                end

`ifdef LED_PATTERN_BREATHE_EN
                // Ramp up; turn around on the tick that reaches the peak.
                // A peak of 0 never satisfies the guard, so the ramp parks
                // at 0 without flipping direction.
                S_BREATHE_UP: begin
                    if (w_tick && (r_active_duty < r_duty)) begin
                        w_active_duty_next = r_active_duty + 8'd1;
                        if ((r_active_duty + 8'd1) == r_duty) begin
                            w_state_next = S_BREATHE_DOWN;
                        end
                    end
                end

                // Ramp down; turn around on the tick that reaches 0.
                S_BREATHE_DOWN: begin
                    if (w_tick && (r_active_duty != 8'd0)) begin
                        w_active_duty_next = r_active_duty - 8'd1;
                        if (r_active_duty == 8'd1) begin
                            w_state_next = S_BREATHE_UP;
                        end
                    end
                end
`endif

                S_ON: begin
                    w_state_next = S_ON;
                end

                default: begin
                    w_state_next = S_OFF;
                end
            endcase
        end
    end

endmodule
